// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses the async instruction ROM,
// and hands registered instructions to decode over a valid/allow handshake.
module inst_fetch_ctrl #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter int          ROM_WORDS = 36,
    parameter int          ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_inst,
    output logic              fetch_valid,
    output logic [31:0]       fetch_inst,
    output logic [31:0]       fetch_pc,
    input  logic              decode_allow,
    input  logic              br_taken,
    input  logic [31:0]       br_target,
    output logic              halt,
    output logic [31:0]       inst_count
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic [31:0] fetch_inst_q, fetch_inst_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        halt_q, halt_d;
    logic [31:0] inst_count_q, inst_count_d;
    logic        pc_in_range;

    // Word-aligned, no bits above the ROM address field, and below the populated size.
    assign pc_in_range = (pc_q[1:0] == 2'b00)
                      && (pc_q[31:ADDR_W+2] == '0)
                      && ({1'b0, pc_q[ADDR_W+1:2]} < ROM_WORDS[ADDR_W:0]);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_valid_d = fetch_valid_q;
        fetch_inst_d  = fetch_inst_q;
        fetch_pc_d    = fetch_pc_q;
        halt_d        = halt_q;
        inst_count_d  = inst_count_q;

        if (fetch_valid_q && decode_allow) begin
            inst_count_d = inst_count_q + 32'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (br_taken) begin
                    pc_d = br_target;
                end else if (pc_in_range) begin
                    fetch_inst_d  = rom_inst;
                    fetch_pc_d    = pc_q;
                    fetch_valid_d = 1'b1;
                    pc_d          = pc_q + 32'd4;
                    state_d       = HOLD;
                end else begin
                    halt_d  = 1'b1;
                    state_d = DONE;
                end
            end
            HOLD: begin
                // A redirect wins over consuming/refilling; nothing is latched from the old PC.
                if (br_taken) begin
                    pc_d          = br_target;
                    fetch_valid_d = 1'b0;
                    state_d       = FETCH;
                end else if (decode_allow) begin
                    if (pc_in_range) begin
                        fetch_inst_d = rom_inst;
                        fetch_pc_d   = pc_q;
                        pc_d         = pc_q + 32'd4;
                    end else begin
                        fetch_valid_d = 1'b0;
                        halt_d        = 1'b1;
                        state_d       = DONE;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= IDLE;
            pc_q          <= PC_RESET;
            fetch_valid_q <= 1'b0;
            fetch_inst_q  <= 32'd0;
            fetch_pc_q    <= 32'd0;
            halt_q        <= 1'b0;
            inst_count_q  <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_inst_q  <= fetch_inst_d;
            fetch_pc_q    <= fetch_pc_d;
            halt_q        <= halt_d;
            inst_count_q  <= inst_count_d;
        end
    end

    assign rom_addr    = pc_q[ADDR_W+1:2];
    assign fetch_valid = fetch_valid_q;
    assign fetch_inst  = fetch_inst_q;
    assign fetch_pc    = fetch_pc_q;
    assign halt        = halt_q;
    assign inst_count  = inst_count_q;

endmodule
